// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module  : riscv_test_monitor
// Brief   : Pass/fail/timeout monitor for riscv-tests runs on 1..8 harts,
//           detecting results by retire-PC match (gp check) or tohost stores.
// Revision: 1.0 - initial release
// ============================================================================
module riscv_test_monitor #(
    parameter int              XLEN        = 32,
    parameter int              NUM_HARTS   = 1,
    parameter int              MODE        = 0,
    parameter logic [XLEN-1:0] PASS_PC     = 'h44,
    parameter logic [XLEN-1:0] TOHOST_ADDR = 'h1000,
    parameter int              TIMEOUT     = 5000,
    parameter int              CNT_W       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_HARTS-1:0]      pc_valid,
    input  logic [NUM_HARTS*XLEN-1:0] pc,
    input  logic [NUM_HARTS*XLEN-1:0] gp,
    input  logic [NUM_HARTS-1:0]      st_valid,
    input  logic [NUM_HARTS*XLEN-1:0] st_addr,
    input  logic [NUM_HARTS*XLEN-1:0] st_data,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [NUM_HARTS-1:0]      hart_done,
    output logic [XLEN-1:0]           fail_code,
    output logic [CNT_W-1:0]          cycles
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [XLEN-1:0]  c_PASS_VAL = XLEN'(1);

    state_t                r_state;
    state_t                w_state_nx;
    logic [NUM_HARTS-1:0]  w_hit;
    logic [NUM_HARTS-1:0]  w_evt;
    logic [NUM_HARTS-1:0]  w_fail;
    logic [XLEN-1:0]       w_val [NUM_HARTS];
    logic [XLEN-1:0]       w_code;
    logic                  w_unused_inputs;

    // Only one detection mode is built; the other mode's inputs are sunk here.
    assign w_unused_inputs = ^{pc_valid, pc, gp, st_valid, st_addr, st_data};

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        if (MODE == 0) begin : g_pc_match
            assign w_hit[h] = pc_valid[h] && (pc[h*XLEN +: XLEN] == PASS_PC);
            assign w_val[h] = gp[h*XLEN +: XLEN];
        end else begin : g_tohost
            // Stores with data[0]=0 are not result writes and are ignored.
            assign w_hit[h] = st_valid[h] && (st_addr[h*XLEN +: XLEN] == TOHOST_ADDR)
                              && st_data[h*XLEN];
            assign w_val[h] = st_data[h*XLEN +: XLEN];
        end
        assign w_evt[h]  = (r_state == S_RUN) && !hart_done[h] && w_hit[h];
        assign w_fail[h] = w_evt[h] && (w_val[h] != c_PASS_VAL);
    end

    always_comb begin
        w_code = '0;
        // Descending scan so the lowest-index failing hart wins.
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (w_fail[h]) begin
                w_code = w_val[h] >> 1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = S_RUN;
        end else if (r_state == S_RUN) begin
            if (|w_fail) begin
                w_state_nx = S_FAIL;
            end else if (&(hart_done | w_evt)) begin
                w_state_nx = S_PASS;
            end else if (cycles == c_TMO_LAST) begin
                w_state_nx = S_TMO;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            hart_done <= '0;
            fail_code <= '0;
            cycles    <= '0;
        end else begin
            done    <= (w_state_nx == S_PASS) || (w_state_nx == S_FAIL) || (w_state_nx == S_TMO);
            pass    <= (w_state_nx == S_PASS);
            timeout <= (w_state_nx == S_TMO);
            if (start) begin
                hart_done <= '0;
                fail_code <= '0;
                cycles    <= '0;
            end else if (r_state == S_RUN) begin
                if (cycles != '1) begin
                    cycles <= cycles + 1'b1;
                end
                hart_done <= hart_done | w_evt;
                if (|w_fail) begin
                    fail_code <= w_code;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_test_monitor
// Brief   : Scoreboard bench for riscv_test_monitor (PC mode, tohost mode, 2 harts).
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscv_test_monitor;

    typedef struct {
        string       tag;
        logic        pass;
        logic        tmo;
        logic [31:0] code;
        logic [31:0] cyc;
        logic [7:0]  hd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    int   sel;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // dut_a: 1 hart, PC mode, short timeout
    logic        pv_a;
    logic [31:0] pc_a, gp_a;
    logic        done_a, pass_a, tmo_a;
    logic [0:0]  hd_a;
    logic [31:0] code_a, cyc_a;
    // dut_b: 1 hart, tohost mode
    logic        sv_b;
    logic [31:0] sa_b, sd_b;
    logic        done_b, pass_b, tmo_b;
    logic [0:0]  hd_b;
    logic [31:0] code_b, cyc_b;
    // dut_c: 2 harts, PC mode
    logic [1:0]  pv_c;
    logic [63:0] pc_c, gp_c;
    logic        done_c, pass_c, tmo_c;
    logic [1:0]  hd_c;
    logic [31:0] code_c, cyc_c;

    logic        m_done, m_pass, m_tmo;
    logic [7:0]  m_hd;
    logic [31:0] m_code, m_cyc;

    always #5 clk = ~clk;

    riscv_test_monitor #(.NUM_HARTS(1), .MODE(0), .TIMEOUT(100)) dut_a (
        .clk(clk), .rst(rst), .start(start),
        .pc_valid(pv_a), .pc(pc_a), .gp(gp_a),
        .st_valid(1'b0), .st_addr(32'h0), .st_data(32'h0),
        .done(done_a), .pass(pass_a), .timeout(tmo_a),
        .hart_done(hd_a), .fail_code(code_a), .cycles(cyc_a));

    riscv_test_monitor #(.NUM_HARTS(1), .MODE(1), .TIMEOUT(100)) dut_b (
        .clk(clk), .rst(rst), .start(start),
        .pc_valid(1'b0), .pc(32'h0), .gp(32'h0),
        .st_valid(sv_b), .st_addr(sa_b), .st_data(sd_b),
        .done(done_b), .pass(pass_b), .timeout(tmo_b),
        .hart_done(hd_b), .fail_code(code_b), .cycles(cyc_b));

    riscv_test_monitor #(.NUM_HARTS(2), .MODE(0), .TIMEOUT(100)) dut_c (
        .clk(clk), .rst(rst), .start(start),
        .pc_valid(pv_c), .pc(pc_c), .gp(gp_c),
        .st_valid(2'b00), .st_addr(64'h0), .st_data(64'h0),
        .done(done_c), .pass(pass_c), .timeout(tmo_c),
        .hart_done(hd_c), .fail_code(code_c), .cycles(cyc_c));

    always_comb begin
        case (sel)
            1: begin
                m_done = done_b; m_pass = pass_b; m_tmo = tmo_b;
                m_hd = {7'd0, hd_b}; m_code = code_b; m_cyc = cyc_b;
            end
            2: begin
                m_done = done_c; m_pass = pass_c; m_tmo = tmo_c;
                m_hd = {6'd0, hd_c}; m_code = code_c; m_cyc = cyc_c;
            end
            default: begin
                m_done = done_a; m_pass = pass_a; m_tmo = tmo_a;
                m_hd = {7'd0, hd_a}; m_code = code_a; m_cyc = cyc_a;
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_cyc < target && guard < 1000) begin
            tick();
            guard++;
        end
        check_eq("run_to", m_cyc, target);
    endtask

    task automatic push_exp(input string tag, input logic p, input logic t,
                            input logic [31:0] code, input logic [31:0] cyc, input logic [7:0] hd);
        exp_t e;
        e.tag = tag; e.pass = p; e.tmo = t; e.code = code; e.cyc = cyc; e.hd = hd;
        sb.push_back(e);
    endtask

    task automatic collect(input int budget);
        exp_t e;
        int   n = 0;
        while (!m_done && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() == 0) begin
            check_eq("sb_nonempty", sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        check_eq({e.tag, ".done"},      m_done, 1);
        check_eq({e.tag, ".pass"},      m_pass, e.pass);
        check_eq({e.tag, ".timeout"},   m_tmo,  e.tmo);
        check_eq({e.tag, ".fail_code"}, m_code, e.code);
        check_eq({e.tag, ".cycles"},    m_cyc,  e.cyc);
        check_eq({e.tag, ".hart_done"}, m_hd,   e.hd);
    endtask

    task automatic clear_inputs();
        pv_a = 1'b0; pc_a = '0; gp_a = '0;
        sv_b = 1'b0; sa_b = '0; sd_b = '0;
        pv_c = '0;   pc_c = '0; gp_c = '0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".done"},   m_done, 0);
        check_eq({tag, ".cycles"}, m_cyc,  0);
        check_eq({tag, ".hd"},     m_hd,   0);
        check_eq({tag, ".code"},   m_code, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; sel = 0;
        clear_inputs();
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            check_idle($sformatf("reset%0d", s));
        end
        rst = 1'b1;

        // PC-mode pass at RUN cycle 10, then terminal hold
        sel = 0;
        tick();
        do_start();
        check_eq("run0.cycles", m_cyc, 0);
        check_eq("run0.done", m_done, 0);
        run_to(10);
        pc_a = 32'h44; gp_a = 32'h1; pv_a = 1'b1;
        push_exp("pc_pass", 1, 0, 0, 11, 1);
        tick();
        clear_inputs();
        collect(3);
        pc_a = 32'h44; gp_a = 32'hB; pv_a = 1'b1;
        repeat (3) tick();
        clear_inputs();
        check_eq("hold.pass", m_pass, 1);
        check_eq("hold.cycles", m_cyc, 11);
        check_eq("hold.code", m_code, 0);

        // PC-mode fail, gp=0xB -> code 5; non-qualified and wrong-PC events ignored
        do_start();
        run_to(1);
        pc_a = 32'h44; gp_a = 32'hB; pv_a = 1'b0;
        tick();
        pc_a = 32'h40; pv_a = 1'b1;
        tick();
        clear_inputs();
        check_eq("ignored.done", m_done, 0);
        check_eq("ignored.hd", m_hd, 0);
        pc_a = 32'h44; gp_a = 32'hB; pv_a = 1'b1;
        push_exp("pc_fail", 0, 0, 5, 4, 1);
        tick();
        clear_inputs();
        collect(3);

        // Timeout after exactly 100 cycles, then restart
        do_start();
        repeat (99) tick();
        check_eq("tmo_early.done", m_done, 0);
        check_eq("tmo_early.cycles", m_cyc, 99);
        push_exp("timeout", 0, 1, 0, 100, 0);
        collect(1);
        do_start();
        check_eq("restart.done", m_done, 0);
        check_eq("restart.timeout", m_tmo, 0);
        check_eq("restart.cycles", m_cyc, 0);
        tick();
        check_eq("restart.count", m_cyc, 1);

        // tohost mode
        sel = 1;
        do_start();
        run_to(2);
        sa_b = 32'h1000; sd_b = 32'h2; sv_b = 1'b1;
        tick();
        clear_inputs();
        check_eq("th_even.done", m_done, 0);
        check_eq("th_even.hd", m_hd, 0);
        run_to(4);
        sa_b = 32'h2000; sd_b = 32'h1; sv_b = 1'b1;
        tick();
        clear_inputs();
        check_eq("th_addr.done", m_done, 0);
        run_to(6);
        sa_b = 32'h1000; sd_b = 32'h1; sv_b = 1'b1;
        push_exp("th_pass", 1, 0, 0, 7, 1);
        tick();
        clear_inputs();
        collect(3);
        do_start();
        run_to(3);
        sa_b = 32'h1000; sd_b = 32'h7; sv_b = 1'b1;
        push_exp("th_fail", 0, 0, 3, 4, 1);
        tick();
        clear_inputs();
        collect(3);

        // two harts: hart0 pass @5, repeat @7 ignored, hart1 fail gp=7 @9
        sel = 2;
        do_start();
        run_to(5);
        pc_c[31:0] = 32'h44; gp_c[31:0] = 32'h1; pv_c = 2'b01;
        tick();
        clear_inputs();
        check_eq("h2.hd_after5", m_hd, 1);
        check_eq("h2.done_after5", m_done, 0);
        run_to(7);
        pc_c[31:0] = 32'h44; gp_c[31:0] = 32'h9; pv_c = 2'b01;
        tick();
        clear_inputs();
        check_eq("h2.repeat_ignored", m_done, 0);
        run_to(9);
        pc_c[63:32] = 32'h44; gp_c[63:32] = 32'h7; pv_c = 2'b10;
        push_exp("h2_fail", 0, 0, 3, 10, 3);
        tick();
        clear_inputs();
        collect(3);

        // simultaneous fails: lowest index wins
        do_start();
        run_to(2);
        pc_c = {32'h44, 32'h44}; gp_c = {32'h7, 32'h5}; pv_c = 2'b11;
        push_exp("h2_both_fail", 0, 0, 2, 3, 3);
        tick();
        clear_inputs();
        collect(3);

        // hart1 then hart0 pass
        do_start();
        run_to(1);
        pc_c[63:32] = 32'h44; gp_c[63:32] = 32'h1; pv_c = 2'b10;
        tick();
        clear_inputs();
        check_eq("h2p.partial_done", m_done, 0);
        check_eq("h2p.partial_hd", m_hd, 2);
        run_to(4);
        pc_c[31:0] = 32'h44; gp_c[31:0] = 32'h1; pv_c = 2'b01;
        push_exp("h2_pass", 1, 0, 0, 5, 3);
        tick();
        clear_inputs();
        collect(3);

        // asynchronous reset mid-run
        sel = 0;
        do_start();
        run_to(5);
        rst = 1'b0;
        #1;
        check_idle("async_rst_a");
        sel = 2;
        #0;
        check_eq("async_rst_c.pass", m_pass, 0);
        check_eq("async_rst_c.hd", m_hd, 0);
        sel = 0;
        repeat (2) tick();
        rst = 1'b1;
        pc_a = 32'h44; gp_a = 32'h1; pv_a = 1'b1;
        repeat (3) tick();
        clear_inputs();
        check_idle("post_rst_idle");

        check_eq("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
